smol_rf_mp: RTL and testbench
=============================

Name: smol_rf_mp

Overview:
Parametrised multi-read-port register file for SmolCore, the next generation of the 32x32 two-read RF.
- Configurable data width, depth, read-port count and hard-wired zero register.
- Synchronous reads with write-to-read bypass.
- Hardware clear sequencer that zeroes the array one entry per cycle, after reset or on request.
- Sits between decode (read) and writeback (write) in the integer pipeline.

Parameters:
XLEN, 32, data width in bits
DEPTH, 32, number of registers (power of two, >=4)
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register
AW, $clog2(DEPTH), address width (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  pulse: restart the clear sweep (ignored while a sweep is running)
we  in  1  write enable
waddr  in  AW  write address
wdata  in  XLEN  write data
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*AW  read addresses; port i at [i*AW +: AW]
rdata  out  NUM_RD*XLEN  read data; port i at [i*XLEN +: XLEN]
rvalid  out  NUM_RD  per-port: rdata for this port updated last cycle
init_busy  out  1  clear sweep in progress; RF not usable

Behaviour:
- Async reset (rst_n low): FSM=INIT, sweep counter=0, rdata=0, rvalid=0, init_busy=1. The array is not reset directly; the sweep clears it.
- FSM states:
  - INIT: each cycle writes 0 to entry cnt, then cnt++. When cnt==DEPTH-1 is written, go to READY next cycle. Sweep takes exactly DEPTH cycles after rst_n rises.
  - READY: normal operation. clr=1 goes to INIT with cnt=0 on the next cycle.
- During INIT:
  - we is ignored and the write is dropped.
  - re is ignored: rvalid=0 and rdata holds its last value.
  - init_busy=1.
  - A clr pulse during INIT does not restart the sweep.
- Write in READY: on the clk edge with we=1, mem[waddr]<=wdata. Suppressed when ZERO_REG=1 and waddr==0.
- Read in READY, per port i:
  - re[i]=1: at the next edge rdata_i is loaded and rvalid[i]=1 (1-cycle latency).
  - re[i]=0: rdata_i holds and rvalid[i]=0.
- Bypass: if we=1, waddr==raddr_i and the write is not suppressed in the same cycle, rdata_i receives wdata (write-first), not the stale array value.
- Zero register: with ZERO_REG=1, raddr_i==0 returns 0 regardless of bypass.
- All ports may read the same address in the same cycle; each gets an identical result.
- clr asserted in READY in the same cycle as we: the write completes, then the sweep starts and clears it.
- Any reads issued in that same cycle complete normally.
- rst_n asserted mid-sweep or mid-operation: immediate return to the reset values; the sweep restarts from 0 after release.

Optional Feature:
Macro SMOL_RF_SCOREBOARD_EN.
- Defined: adds inputs claim (1), claim_addr (AW) and output rbusy (NUM_RD).
  - Per-entry pending bit set at the edge where claim=1, cleared at the edge where a READY write hits that address.
  - If claim and write hit the same address in one cycle, pending ends set (a new producer).
  - rbusy[i] is registered alongside rdata_i and reflects the pending state after that cycle's claim and write.
  - Entry 0 is never pending when ZERO_REG=1.
  - All pending bits clear on reset and on entry to INIT.
- Not defined: ports absent, no pending storage.

Test Plan:
- Reset then idle (DEPTH=32): init_busy=1 for exactly 32 cycles after rst_n rises, then 0. A read of every address on every port returns 0 with rvalid=1.
- READY: write 0xDEADBEEF to r5. Next cycle re[0]=1, raddr0=5 -> one cycle later rdata0=0xDEADBEEF, rvalid[0]=1.
- Same-cycle write 0x1234 to r7 with raddr0=raddr1=7, re=2'b11 -> next cycle rdata0=rdata1=0x1234 (bypass).
- ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 -> 0. With ZERO_REG=0 the same sequence -> 0xFFFFFFFF.
- Write 0xA5A5 to r3, pulse clr, we=1 during the sweep -> init_busy high 32 cycles, write dropped, subsequent read of r3 -> 0.
- rst_n low at sweep cycle 10 for 2 cycles -> rvalid=0 immediately; a fresh 32-cycle sweep follows. With SMOL_RF_SCOREBOARD_EN, claim r9 -> rbusy=1 on a read of r9 until a write to r9, then 0.

Source files
------------

// File: rtl/smol_rf_mp.sv
// Parametrised multi-read-port register file with synchronous bypassed reads and a clear sweep.
// Optional pending-write scoreboard enabled by defining SMOL_RF_SCOREBOARD_EN.
module smol_rf_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic [NUM_RD-1:0]      re,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic [NUM_RD-1:0]      rvalid,
`ifdef SMOL_RF_SCOREBOARD_EN
    input  logic                   claim,
    input  logic [AW-1:0]          claim_addr,
    output logic [NUM_RD-1:0]      rbusy,
`endif
    output logic                   init_busy
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [XLEN-1:0]         mem_q [DEPTH];
    logic                    mem_we;
    logic [AW-1:0]           mem_waddr;
    logic [XLEN-1:0]         mem_wdata;
    logic                    wr_ok;
    logic [NUM_RD*XLEN-1:0]  rdata_q, rdata_d;
    logic [NUM_RD-1:0]       rvalid_q, rvalid_d;

`ifdef SMOL_RF_SCOREBOARD_EN
    logic [DEPTH-1:0]        pend_q, pend_d, pend_nxt;
    logic [NUM_RD-1:0]       rbusy_q, rbusy_d;
`endif

    always_comb begin : fsm_and_write
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        wr_ok     = (state_q == ST_READY) && we && !((ZERO_REG != 0) && (waddr == '0));
        case (state_q)
            ST_INIT: begin
                // The sweep owns the write port; external writes are dropped.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we = wr_ok;
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin : read_path
        logic [AW-1:0] ra;
        ra       = '0;
        rdata_d  = rdata_q;
        rvalid_d = '0;
`ifdef SMOL_RF_SCOREBOARD_EN
        rbusy_d  = rbusy_q;
        pend_nxt = pend_q;
        if (wr_ok) begin
            pend_nxt[waddr] = 1'b0;
        end
        // Claim after the write so a same-cycle claim marks a new producer.
        if ((state_q == ST_READY) && claim) begin
            pend_nxt[claim_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_nxt[0] = 1'b0;
        end
        pend_d = ((state_q == ST_INIT) || clr) ? '0 : pend_nxt;
`endif
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra = raddr[i*AW +: AW];
            if ((state_q == ST_READY) && re[i]) begin
                rvalid_d[i] = 1'b1;
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    rdata_d[i*XLEN +: XLEN] = '0;
                end else if (wr_ok && (waddr == ra)) begin
                    rdata_d[i*XLEN +: XLEN] = wdata;
                end else begin
                    rdata_d[i*XLEN +: XLEN] = mem_q[ra];
                end
`ifdef SMOL_RF_SCOREBOARD_EN
                rbusy_d[i] = pend_nxt[ra];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // The array has no reset; the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef SMOL_RF_SCOREBOARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            rbusy_q <= '0;
        end else begin
            pend_q  <= pend_d;
            rbusy_q <= rbusy_d;
        end
    end

    assign rbusy = rbusy_q;
`endif

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_smol_rf_mp.sv
// Directed self-checking bench for smol_rf_mp: one instance with ZERO_REG=1, one with ZERO_REG=0.
module tb_smol_rf_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [31:0]   wdata = '0;
    logic [1:0]    re    = '0;
    logic [9:0]    raddr = '0;
    logic [63:0]   rdata, rdata_z;
    logic [1:0]    rvalid, rvalid_z;
    logic          init_busy, init_busy_z;
`ifdef SMOL_RF_SCOREBOARD_EN
    logic          claim      = 1'b0;
    logic [AW-1:0] claim_addr = '0;
    logic [1:0]    rbusy, rbusy_z;
`endif

    int checks = 0;
    int errors = 0;

    smol_rf_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
`ifdef SMOL_RF_SCOREBOARD_EN
        .claim(claim), .claim_addr(claim_addr), .rbusy(rbusy),
`endif
        .init_busy(init_busy)
    );

    smol_rf_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_z), .rvalid(rvalid_z),
`ifdef SMOL_RF_SCOREBOARD_EN
        .claim(claim), .claim_addr(claim_addr), .rbusy(rbusy_z),
`endif
        .init_busy(init_busy_z)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        step();
        step();
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", init_busy); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", rvalid); end
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        rst_n = 1'b1;
        n = 0;
        while (init_busy && n < 100) begin step(); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL reset_sweep_len got %0d want 32", n); end
        checks++; if (init_busy_z !== 1'b0) begin errors++; $display("FAIL reset_sweep_z got %0b want 0", init_busy_z); end
        for (int a = 0; a < 32; a++) begin
            re = 2'b11;
            raddr = {5'(a), 5'(a)};
            step();
            checks++; if (rdata !== 64'h0 || rvalid !== 2'b11) begin
                errors++; $display("FAIL reset_read_all a=%0d got %h/%b want 0/11", a, rdata, rvalid);
            end
            checks++; if (rdata_z !== 64'h0 || rvalid_z !== 2'b11) begin
                errors++; $display("FAIL reset_read_all_z a=%0d got %h/%b want 0/11", a, rdata_z, rvalid_z);
            end
        end
        re = 2'b00;
    endtask

    task automatic test_read_after_write;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        waddr = 5'd6; wdata = 32'h0000600D;
        step();
        we = 1'b0;
        re = 2'b01; raddr = {5'd6, 5'd5};
        step();
        checks++; if (rdata[31:0] !== 32'hDEADBEEF || rvalid !== 2'b01) begin
            errors++; $display("FAIL raw_port0 got %h/%b want deadbeef/01", rdata[31:0], rvalid);
        end
        re = 2'b11;
        step();
        checks++; if (rdata !== {32'h0000600D, 32'hDEADBEEF} || rvalid !== 2'b11) begin
            errors++; $display("FAIL raw_two_ports got %h/%b want 0000600ddeadbeef/11", rdata, rvalid);
        end
        re = 2'b00;
    endtask

    task automatic test_hold;
        re = 2'b00; raddr = {5'd1, 5'd1};
        step();
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL hold_rvalid got %b want 00", rvalid); end
        checks++; if (rdata !== {32'h0000600D, 32'hDEADBEEF}) begin
            errors++; $display("FAIL hold_rdata got %h want 0000600ddeadbeef", rdata);
        end
    endtask

    task automatic test_bypass;
        we = 1'b1; waddr = 5'd7; wdata = 32'h00001234;
        re = 2'b11; raddr = {5'd7, 5'd7};
        step();
        we = 1'b0;
        checks++; if (rdata !== {32'h00001234, 32'h00001234} || rvalid !== 2'b11) begin
            errors++; $display("FAIL bypass got %h/%b want 0000123400001234/11", rdata, rvalid);
        end
        re = 2'b10; raddr = {5'd7, 5'd0};
        step();
        checks++; if (rdata[63:32] !== 32'h00001234 || rvalid !== 2'b10) begin
            errors++; $display("FAIL bypass_landed got %h/%b want 00001234/10", rdata[63:32], rvalid);
        end
        re = 2'b00;
    endtask

    task automatic test_zero_reg;
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        step();
        we = 1'b0;
        re = 2'b01; raddr = 10'd0;
        step();
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL zero_reg got %h want 0", rdata[31:0]); end
        checks++; if (rdata_z[31:0] !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL zero_reg_off got %h want ffffffff", rdata_z[31:0]);
        end
        we = 1'b1; waddr = 5'd0; wdata = 32'h00000055;
        re = 2'b11; raddr = 10'd0;
        step();
        we = 1'b0;
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL zero_bypass got %h want 0", rdata); end
        checks++; if (rdata_z !== {32'h55, 32'h55}) begin
            errors++; $display("FAIL zero_bypass_off got %h want 0000005500000055", rdata_z);
        end
        re = 2'b00;
    endtask

`ifdef SMOL_RF_SCOREBOARD_EN
    task automatic test_scoreboard;
        claim = 1'b1; claim_addr = 5'd9;
        step();
        claim = 1'b0;
        re = 2'b11; raddr = {5'd8, 5'd9};
        step();
        checks++; if (rbusy !== 2'b01) begin errors++; $display("FAIL sb_claimed got %b want 01", rbusy); end
        we = 1'b1; waddr = 5'd9; wdata = 32'h00000099;
        re = 2'b01; raddr = {5'd8, 5'd9};
        step();
        we = 1'b0;
        checks++; if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h99) begin
            errors++; $display("FAIL sb_written got %b/%h want 0/00000099", rbusy[0], rdata[31:0]);
        end
        claim = 1'b1; claim_addr = 5'd0;
        step();
        claim = 1'b0;
        re = 2'b01; raddr = 10'd0;
        step();
        checks++; if (rbusy[0] !== 1'b0 || rbusy_z[0] !== 1'b1) begin
            errors++; $display("FAIL sb_zero got %b/%b want 0/1", rbusy[0], rbusy_z[0]);
        end
        we = 1'b1; waddr = 5'd0; wdata = 32'h0;
        step();
        we = 1'b0;
        re = 2'b00;
    endtask
`endif

    task automatic test_clr_sweep;
        int n;
        we = 1'b1; waddr = 5'd3; wdata = 32'h0000A5A5;
        clr = 1'b1; re = 2'b01; raddr = {5'd3, 5'd3};
        step();
        clr = 1'b0;
        checks++; if (rdata[31:0] !== 32'h0000A5A5 || rvalid !== 2'b01 || init_busy !== 1'b1) begin
            errors++; $display("FAIL clr_same_cycle got %h/%b/%0b want 0000a5a5/01/1", rdata[31:0], rvalid, init_busy);
        end
        wdata = 32'h00007777; re = 2'b11;
        n = 0;
        while (init_busy && n < 100) begin
            step();
            n++;
            if (init_busy) begin
                checks++; if (rvalid !== 2'b00) begin
                    errors++; $display("FAIL clr_rvalid n=%0d got %b want 00", n, rvalid);
                end
            end
        end
        we = 1'b0;
        checks++; if (n != 32) begin errors++; $display("FAIL clr_sweep_len got %0d want 32", n); end
        checks++; if (rdata[31:0] !== 32'h0000A5A5) begin
            errors++; $display("FAIL clr_rdata_hold got %h want 0000a5a5", rdata[31:0]);
        end
        re = 2'b11; raddr = {5'd5, 5'd3};
        step();
        checks++; if (rdata !== 64'h0 || rvalid !== 2'b11) begin
            errors++; $display("FAIL clr_cleared got %h/%b want 0/11", rdata, rvalid);
        end
        checks++; if (rdata_z !== 64'h0) begin errors++; $display("FAIL clr_cleared_z got %h want 0", rdata_z); end
        re = 2'b00;
    endtask

    task automatic test_reset_async;
        int n;
        we = 1'b1; waddr = 5'd4; wdata = 32'h0000CAFE;
        step();
        we = 1'b0;
        re = 2'b01; raddr = {5'd0, 5'd4};
        step();
        re = 2'b00;
        checks++; if (rdata[31:0] !== 32'h0000CAFE || rvalid !== 2'b01) begin
            errors++; $display("FAIL async_pre got %h/%b want 0000cafe/01", rdata[31:0], rvalid);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (rvalid !== 2'b00 || rdata !== 64'h0 || init_busy !== 1'b1) begin
            errors++; $display("FAIL async_immediate got %b/%h/%0b want 00/0/1", rvalid, rdata, init_busy);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL async_midsweep got %0b want 1", init_busy); end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        while (init_busy && n < 100) begin step(); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL async_resweep_len got %0d want 32", n); end
        re = 2'b11; raddr = {5'd7, 5'd4};
        step();
        checks++; if (rdata !== 64'h0 || rvalid !== 2'b11) begin
            errors++; $display("FAIL async_cleared got %h/%b want 0/11", rdata, rvalid);
        end
        re = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_after_write();
        test_hold();
        test_bypass();
        test_zero_reg();
`ifdef SMOL_RF_SCOREBOARD_EN
        test_scoreboard();
`endif
        test_clr_sweep();
        test_reset_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
